// File: rtl/lbs_axis_conv.sv
`default_nettype none
// ============================================================================
// Module : lbs_axis_conv
// Brief  : Local-bus loaded TX/RX sample buffers bridged to AXI-Stream ch 0.
// Rev    : 1.0  initial release
// ============================================================================
module lbs_axis_conv #(
    parameter int BUF_DEPTH = 2304,
    parameter int TX_BASE   = 12000,
    parameter int RX_BASE   = 8000,
    parameter int CTRL_ADDR = 16000,
    parameter int STAT_ADDR = 16001,
    parameter int LED_DIV   = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] lbs_addr,
    input  logic [31:0] lbs_din,
    input  logic        lbs_we,
    input  logic        lbs_re,
    output logic [31:0] lbs_dout,
    input  logic        axis_0_rx_tvalid,
    input  logic [31:0] axis_0_rx_tdata,
    input  logic        axis_0_rx_tlast,
    output logic        axis_0_rx_tready,
    input  logic        axis_1_rx_tvalid,
    input  logic [31:0] axis_1_rx_tdata,
    input  logic        axis_1_rx_tlast,
    output logic        axis_1_rx_tready,
    output logic        axis_0_tx_tvalid,
    output logic [31:0] axis_0_tx_tdata,
    output logic        axis_0_tx_tlast,
    input  logic        axis_0_tx_tready,
    output logic        axis_1_tx_tvalid,
    output logic [31:0] axis_1_tx_tdata,
    output logic        axis_1_tx_tlast,
    input  logic        axis_1_tx_tready,
    output logic        led_pulse
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int LW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;

    localparam logic [15:0]   TX_LO   = 16'(TX_BASE);
    localparam logic [15:0]   TX_HI   = 16'(TX_BASE + BUF_DEPTH);
    localparam logic [15:0]   RX_LO   = 16'(RX_BASE);
    localparam logic [15:0]   RX_HI   = 16'(RX_BASE + BUF_DEPTH);
    localparam logic [15:0]   CTRL_A  = 16'(CTRL_ADDR);
    localparam logic [15:0]   STAT_A  = 16'(STAT_ADDR);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(BUF_DEPTH - 1);
    localparam logic [LW-1:0] LED_END = LW'(LED_DIV - 1);

    localparam logic [15:0] CMD_LOAD  = 16'h5555;
    localparam logic [15:0] CMD_IDLE  = 16'h8888;
    localparam logic [15:0] CMD_START = 16'hFFFF;
    localparam logic [15:0] CMD_ABORT = 16'h0000;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_TX   = 1'b1;

    localparam logic [2:0] SEL_ZERO = 3'd0;
    localparam logic [2:0] SEL_TX   = 3'd1;
    localparam logic [2:0] SEL_RX   = 3'd2;
    localparam logic [2:0] SEL_CTRL = 3'd3;
    localparam logic [2:0] SEL_STAT = 3'd4;

    logic [31:0]   tx_mem [BUF_DEPTH];
    logic [31:0]   rx_mem [BUF_DEPTH];

    logic [0:0]    r_state;
    logic          r_load_mode;
    logic          r_armed;
    logic          r_rx_done;
    logic [CW-1:0] r_rx_count;
    logic [CW-1:0] r_tx_idx;
    logic [15:0]   r_ctrl;
    logic [LW-1:0] r_led_cnt;

    logic          r_rd_pend;
    logic          r_rd_pend2;
    logic [15:0]   r_rd_addr;
    logic [2:0]    r_rd_sel;
    logic [31:0]   r_tx_q;
    logic [31:0]   r_rx_q;

    logic          w_tx_busy;
    logic          w_ctrl_wr;
    logic          w_tx_wr;
    logic          w_rx_fire;
    logic [AW-1:0] w_wr_off;
    logic [AW-1:0] w_rd_tx_off;
    logic [AW-1:0] w_rd_rx_off;
    logic [2:0]    w_rd_sel;
    logic [31:0]   w_stat;
    logic          w_unused_ok;

    assign w_tx_busy   = (r_state == S_TX);
    assign w_ctrl_wr   = lbs_we && (lbs_addr == CTRL_A);
    assign w_wr_off    = AW'(lbs_addr - TX_LO);
    assign w_tx_wr     = lbs_we && r_load_mode && (lbs_addr >= TX_LO) && (lbs_addr < TX_HI);
    assign w_rx_fire   = axis_0_rx_tvalid && axis_0_rx_tready;
    assign w_rd_tx_off = AW'(r_rd_addr - TX_LO);
    assign w_rd_rx_off = AW'(r_rd_addr - RX_LO);
    assign w_stat      = {{(16 - CW){1'b0}}, r_rx_count, 13'd0, r_rx_done, w_tx_busy, r_load_mode};

    assign axis_0_rx_tready = r_armed && (r_rx_count < DEPTH_C) && !r_rx_done;
    assign axis_1_rx_tready = 1'b1;
    assign axis_1_tx_tvalid = 1'b0;
    assign axis_1_tx_tdata  = 32'd0;
    assign axis_1_tx_tlast  = 1'b0;
    assign w_unused_ok = &{1'b0, axis_1_rx_tvalid, axis_1_rx_tdata, axis_1_rx_tlast, axis_1_tx_tready};

    always_comb begin
        w_rd_sel = SEL_ZERO;
        if ((r_rd_addr >= TX_LO) && (r_rd_addr < TX_HI))      w_rd_sel = SEL_TX;
        else if ((r_rd_addr >= RX_LO) && (r_rd_addr < RX_HI)) w_rd_sel = SEL_RX;
        else if (r_rd_addr == CTRL_A)                         w_rd_sel = SEL_CTRL;
        else if (r_rd_addr == STAT_A)                         w_rd_sel = SEL_STAT;
    end

    // Buffer RAMs: one bus/stream write port, registered bus read port.
    always_ff @(posedge clk) begin
        if (w_tx_wr) tx_mem[w_wr_off] <= lbs_din;
        r_tx_q <= tx_mem[w_rd_tx_off];
    end

    always_ff @(posedge clk) begin
        if (w_rx_fire) rx_mem[r_rx_count[AW-1:0]] <= axis_0_rx_tdata;
        r_rx_q <= rx_mem[w_rd_rx_off];
    end

    // Bus read pipeline: address capture, RAM access, output mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_pend2 <= 1'b0;
            r_rd_addr  <= 16'd0;
            r_rd_sel   <= SEL_ZERO;
            lbs_dout   <= 32'd0;
        end else begin
            r_rd_pend  <= lbs_re && !lbs_we;
            if (lbs_re && !lbs_we) r_rd_addr <= lbs_addr;
            r_rd_pend2 <= r_rd_pend;
            r_rd_sel   <= w_rd_sel;
            if (r_rd_pend2) begin
                case (r_rd_sel)
                    SEL_TX:   lbs_dout <= r_tx_q;
                    SEL_RX:   lbs_dout <= r_rx_q;
                    SEL_CTRL: lbs_dout <= {16'd0, r_ctrl};
                    SEL_STAT: lbs_dout <= w_stat;
                    default:  lbs_dout <= 32'd0;
                endcase
            end
        end
    end

    // Playout, capture and command decode; commands override the stream step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_load_mode      <= 1'b0;
            r_armed          <= 1'b0;
            r_rx_done        <= 1'b0;
            r_rx_count       <= '0;
            r_tx_idx         <= '0;
            r_ctrl           <= 16'd0;
            axis_0_tx_tvalid <= 1'b0;
            axis_0_tx_tdata  <= 32'd0;
            axis_0_tx_tlast  <= 1'b0;
        end else begin
            if (w_rx_fire) begin
                r_rx_count <= r_rx_count + 1'b1;
                if (axis_0_rx_tlast || (r_rx_count == LAST_C)) r_rx_done <= 1'b1;
            end
            if ((r_state == S_TX) && (!axis_0_tx_tvalid || axis_0_tx_tready)) begin
                if (axis_0_tx_tvalid && axis_0_tx_tlast) begin
                    r_state          <= S_IDLE;
                    axis_0_tx_tvalid <= 1'b0;
                    axis_0_tx_tlast  <= 1'b0;
                end else begin
                    axis_0_tx_tvalid <= 1'b1;
                    axis_0_tx_tdata  <= tx_mem[r_tx_idx[AW-1:0]];
                    axis_0_tx_tlast  <= (r_tx_idx == LAST_C);
                    r_tx_idx         <= r_tx_idx + 1'b1;
                end
            end
            if (w_ctrl_wr) begin
                case (lbs_din[15:0])
                    CMD_LOAD, CMD_IDLE, CMD_ABORT: begin
                        r_ctrl           <= lbs_din[15:0];
                        r_state          <= S_IDLE;
                        axis_0_tx_tvalid <= 1'b0;
                        axis_0_tx_tlast  <= 1'b0;
                        if (lbs_din[15:0] == CMD_LOAD) r_load_mode <= 1'b1;
                        if (lbs_din[15:0] == CMD_IDLE) r_load_mode <= 1'b0;
                        if (lbs_din[15:0] != CMD_IDLE) r_armed     <= 1'b0;
                    end
                    CMD_START: begin
                        if ((r_state == S_IDLE) && !r_load_mode) begin
                            r_ctrl     <= CMD_START;
                            r_state    <= S_TX;
                            r_tx_idx   <= '0;
                            r_rx_count <= '0;
                            r_rx_done  <= 1'b0;
                            r_armed    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led_cnt <= '0;
            led_pulse <= 1'b0;
        end else if (r_led_cnt == LED_END) begin
            r_led_cnt <= '0;
            led_pulse <= ~led_pulse;
        end else begin
            r_led_cnt <= r_led_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lbs_axis_conv.sv
`default_nettype none
// Bench for lbs_axis_conv: bus load/readback, loopback playout, abort, LED and reset.
module tb_lbs_axis_conv;

    localparam int DEPTH = 2304;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] lbs_addr;
    logic [31:0] lbs_din;
    logic        lbs_we, lbs_re;
    logic [31:0] lbs_dout;
    logic        axis_0_rx_tvalid, axis_0_rx_tlast, axis_0_rx_tready;
    logic [31:0] axis_0_rx_tdata;
    logic        axis_1_rx_tvalid, axis_1_rx_tlast, axis_1_rx_tready;
    logic [31:0] axis_1_rx_tdata;
    logic        axis_0_tx_tvalid, axis_0_tx_tlast, axis_0_tx_tready;
    logic [31:0] axis_0_tx_tdata;
    logic        axis_1_tx_tvalid, axis_1_tx_tlast, axis_1_tx_tready;
    logic [31:0] axis_1_tx_tdata;
    logic        led_pulse;

    logic loop_en, bp, man_ready;

    always #5 clk = ~clk;

    assign axis_0_rx_tvalid = loop_en & axis_0_tx_tvalid & bp;
    assign axis_0_rx_tdata  = axis_0_tx_tdata;
    assign axis_0_rx_tlast  = 1'b0;
    assign axis_0_tx_tready = loop_en ? (axis_0_rx_tready & bp) : man_ready;

    lbs_axis_conv #(.LED_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .lbs_addr(lbs_addr), .lbs_din(lbs_din), .lbs_we(lbs_we), .lbs_re(lbs_re), .lbs_dout(lbs_dout),
        .axis_0_rx_tvalid(axis_0_rx_tvalid), .axis_0_rx_tdata(axis_0_rx_tdata),
        .axis_0_rx_tlast(axis_0_rx_tlast), .axis_0_rx_tready(axis_0_rx_tready),
        .axis_1_rx_tvalid(axis_1_rx_tvalid), .axis_1_rx_tdata(axis_1_rx_tdata),
        .axis_1_rx_tlast(axis_1_rx_tlast), .axis_1_rx_tready(axis_1_rx_tready),
        .axis_0_tx_tvalid(axis_0_tx_tvalid), .axis_0_tx_tdata(axis_0_tx_tdata),
        .axis_0_tx_tlast(axis_0_tx_tlast), .axis_0_tx_tready(axis_0_tx_tready),
        .axis_1_tx_tvalid(axis_1_tx_tvalid), .axis_1_tx_tdata(axis_1_tx_tdata),
        .axis_1_tx_tlast(axis_1_tx_tlast), .axis_1_tx_tready(axis_1_tx_tready),
        .led_pulse(led_pulse)
    );

    typedef struct {
        logic [15:0] addr;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [32:0] exp_q [$];
    int          tx_beats = 0;
    bit          mon_en = 0;
    bit          stall_en = 0;
    logic        stall_v = 1'b0;
    logic [32:0] stall_w = '0;
    logic [31:0] rd_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Sampled at the falling edge: shows what the next rising edge will see.
    task automatic mon_step();
        logic [32:0] e;
        if (mon_en && stall_en && stall_v) begin
            check("tx_stall_tvalid", 64'(axis_0_tx_tvalid), 64'd1);
            check("tx_stall_word", 64'({axis_0_tx_tlast, axis_0_tx_tdata}), 64'(stall_w));
        end
        if (mon_en && axis_0_tx_tvalid && axis_0_tx_tready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL tx_unexpected_beat: got tdata 0x%08h tlast %0d, required no beat",
                         axis_0_tx_tdata, axis_0_tx_tlast);
            end else begin
                e = exp_q.pop_front();
                check("tx_beat", 64'({axis_0_tx_tlast, axis_0_tx_tdata}), 64'(e));
                tx_beats++;
            end
        end
        stall_v = axis_0_tx_tvalid && !axis_0_tx_tready;
        stall_w = {axis_0_tx_tlast, axis_0_tx_tdata};
    endtask

    task automatic tick();
        @(negedge clk);
        mon_step();
        @(posedge clk);
        #1;
    endtask

    task automatic lbs_write(input logic [15:0] a, input logic [31:0] d);
        lbs_addr = a;
        lbs_din  = d;
        lbs_we   = 1'b1;
        tick();
        lbs_we   = 1'b0;
    endtask

    task automatic lbs_read(input logic [15:0] a, output logic [31:0] d);
        lbs_addr = a;
        lbs_re   = 1'b1;
        tick();
        lbs_re   = 1'b0;
        tick();
        tick();
        d = lbs_dout;
    endtask

    task automatic push_frame(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == DEPTH - 1), 16'(i), 16'(i)});
    endtask

    initial begin
        rd_vec_t rv [9];
        int      base;
        int      k;

        rv[0] = '{16'd12000, 32'h0000_0000, "rd_tx_word0"};
        rv[1] = '{16'd12005, 32'h0005_0005, "rd_tx_word5"};
        rv[2] = '{16'd13000, 32'h03E8_03E8, "rd_tx_word1000"};
        rv[3] = '{16'd14303, 32'h08FF_08FF, "rd_tx_last"};
        rv[4] = '{16'd14304, 32'h0000_0000, "rd_past_tx_end"};
        rv[5] = '{16'd11999, 32'h0000_0000, "rd_before_tx"};
        rv[6] = '{16'd16000, 32'h0000_8888, "rd_ctrl"};
        rv[7] = '{16'd16001, 32'h0000_0000, "rd_stat_idle"};
        rv[8] = '{16'd65535, 32'h0000_0000, "rd_unmapped"};

        rst = 1'b1; lbs_addr = '0; lbs_din = '0; lbs_we = 1'b0; lbs_re = 1'b0;
        loop_en = 1'b0; bp = 1'b1; man_ready = 1'b0;
        axis_1_rx_tvalid = 1'b1; axis_1_rx_tdata = 32'hA5A5_0001; axis_1_rx_tlast = 1'b1;
        axis_1_tx_tready = 1'b1;

        for (int i = 0; i < 5; i++) tick();
        check("rst_tx_tvalid", 64'(axis_0_tx_tvalid), 64'd0);
        check("rst_tx_tdata", 64'(axis_0_tx_tdata), 64'd0);
        check("rst_tx_tlast", 64'(axis_0_tx_tlast), 64'd0);
        check("rst_rx0_tready", 64'(axis_0_rx_tready), 64'd0);
        check("rst_rx1_tready", 64'(axis_1_rx_tready), 64'd1);
        check("rst_tx1_all", 64'({axis_1_tx_tvalid, axis_1_tx_tlast, axis_1_tx_tdata}), 64'd0);
        check("rst_led", 64'(led_pulse), 64'd0);
        check("rst_dout", 64'(lbs_dout), 64'd0);
        rst = 1'b0;
        tick();
        lbs_read(16'd16001, rd_data);
        check("rst_stat", 64'(rd_data), 64'd0);

        lbs_write(16'd16000, 32'h5555);
        lbs_read(16'd16001, rd_data);
        check("stat_load_mode", 64'(rd_data), 64'd1);
        for (int i = 0; i < DEPTH; i++) lbs_write(16'(12000 + i), {16'(i), 16'(i)});
        lbs_write(16'd16000, 32'h8888);
        for (int i = 0; i < 9; i++) begin
            lbs_read(rv[i].addr, rd_data);
            check(rv[i].name, 64'(rd_data), 64'(rv[i].exp));
        end
        lbs_write(16'd12005, 32'hDEAD_BEEF);
        lbs_read(16'd12005, rd_data);
        check("tx_write_outside_load", 64'(rd_data), 64'h0005_0005);

        // Loopback playout with random backpressure.
        mon_en = 1; stall_en = 1; loop_en = 1'b1; bp = 1'b1;
        push_frame(DEPTH);
        lbs_write(16'd16000, 32'hFFFF);
        k = 0;
        while (!axis_0_tx_tvalid && k < 3) begin tick(); k++; end
        check("tvalid_within_3", 64'(axis_0_tx_tvalid), 64'd1);
        k = 0;
        while (exp_q.size() != 0 && k < 20000) begin
            bp = ($urandom_range(0, 3) != 0);
            tick();
            k++;
        end
        bp = 1'b1;
        check("loopback_remaining", 64'(exp_q.size()), 64'd0);
        tick(); tick();
        check("loopback_tvalid_end", 64'(axis_0_tx_tvalid), 64'd0);
        check("loopback_rx_tready_end", 64'(axis_0_rx_tready), 64'd0);
        lbs_read(16'd16001, rd_data);
        check("loopback_stat", 64'(rd_data), 64'h0900_0004);
        lbs_read(16'd8007, rd_data);
        check("rx_word7", 64'(rd_data), 64'h0007_0007);
        lbs_read(16'd10303, rd_data);
        check("rx_word_last", 64'(rd_data), 64'h08FF_08FF);

        // Abort after 100 accepted beats.
        loop_en = 1'b0; man_ready = 1'b1;
        push_frame(100);
        base = tx_beats;
        lbs_write(16'd16000, 32'hFFFF);
        k = 0;
        while ((tx_beats - base) < 100 && k < 500) begin tick(); k++; end
        man_ready = 1'b0;
        check("abort_beats_before", 64'(tx_beats - base), 64'd100);
        tick();
        check("abort_stalled_tvalid", 64'(axis_0_tx_tvalid), 64'd1);
        stall_en = 0;
        lbs_write(16'd16000, 32'h5555);
        check("abort_tvalid", 64'(axis_0_tx_tvalid), 64'd0);
        check("abort_tlast", 64'(axis_0_tx_tlast), 64'd0);
        man_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        lbs_read(16'd16001, rd_data);
        check("abort_stat", 64'(rd_data), 64'd1);
        lbs_write(16'd16000, 32'hFFFF);
        for (int i = 0; i < 4; i++) tick();
        check("start_in_load_tvalid", 64'(axis_0_tx_tvalid), 64'd0);
        lbs_read(16'd16001, rd_data);
        check("start_in_load_stat", 64'(rd_data), 64'd1);
        lbs_read(16'd16000, rd_data);
        check("start_in_load_ctrl", 64'(rd_data), 64'h5555);

        // LED: period of 8 cycles from reset.
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            check("led_phase", 64'(led_pulse), 64'((t / 4) % 2));
        end

        // Reset in the middle of a playout.
        mon_en = 0;
        lbs_write(16'd16000, 32'hFFFF);
        for (int i = 0; i < 10; i++) tick();
        check("midrun_tvalid", 64'(axis_0_tx_tvalid), 64'd1);
        rst = 1'b1;
        tick();
        check("midrst_tvalid", 64'(axis_0_tx_tvalid), 64'd0);
        check("midrst_tdata", 64'(axis_0_tx_tdata), 64'd0);
        check("midrst_rx1_tready", 64'(axis_1_rx_tready), 64'd1);
        check("midrst_dout", 64'(lbs_dout), 64'd0);
        rst = 1'b0;
        tick();
        lbs_read(16'd16001, rd_data);
        check("midrst_stat", 64'(rd_data), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
